// File: rtl/pulse_trig_pkg.sv
// Shared types for the pulse-width trigger.
// Provides the trigger mode encoding carried on i_mode, and the per-channel
// qualifier state. The top level exposes that state on its debug port.
package pulse_trig_pkg;

   // Value 3 on i_mode is reserved. Channels treat it as RELEASE.
   typedef enum logic [1:0] {
      RELEASE = 2'd0,
      HOLD    = 2'd1,
      REPEAT  = 2'd2
   } trig_mode_e;

   localparam logic [1:0] MODE_RESERVED = 2'd3;

   typedef enum logic [2:0] {
      DISARMED = 3'd0,
      IDLE     = 3'd1,
      COUNT    = 3'd2,
      QUAL     = 3'd3,
      OVER     = 3'd4
   } chan_state_e;

   localparam int STATE_W = 3;

endpackage

// File: rtl/pulse_trig_channel.sv
// One pulse-width qualifier channel. It contains the input synchroniser,
// the width counter, the qualifier FSM and the repeat period counter.
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_in                      raw asynchronous input
//   i_active_low              1: the channel is asserted while i_in is low
//   i_mode                    RELEASE / HOLD / REPEAT (3 acts as RELEASE)
//   i_min_cycles/i_max_cycles width window (min 0 acts as 1, max 0 = unbounded)
//   o_fire                    unregistered strobe; o_strobe is this value registered
//   o_strobe, o_qualified     registered channel outputs
//   o_state                   current FSM state (debug)
module pulse_trig_channel
   import pulse_trig_pkg::*;
#(
   parameter int CNT_W       = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_in,
   input  logic             i_active_low,
   input  logic [1:0]       i_mode,
   input  logic [CNT_W-1:0] i_min_cycles,
   input  logic [CNT_W-1:0] i_max_cycles,
   output logic             o_fire,
   output logic             o_strobe,
   output logic             o_qualified,
   output chan_state_e      o_state
);

   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [1:0]       FILL_DONE = 2'(SYNC_STAGES);

   logic sync_out;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign sync_out = i_in;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] sync_q;
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               sync_q <= {SYNC_STAGES{i_active_low}};
            end else begin
               sync_q[0] <= i_in;
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  sync_q[i] <= sync_q[i-1];
               end
            end
         end
         assign sync_out = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   // After reset the synchroniser still holds its reset value for
   // SYNC_STAGES samples. If DISARMED saw those samples, it would arm on them.
   // An input held asserted through reset would then trigger. Arming waits
   // until real pin samples reach the end of the chain.
   logic [1:0] fill_q, fill_d;
   logic       sample_ok;
   assign sample_ok = (fill_q == FILL_DONE);
   assign fill_d    = sample_ok ? fill_q : fill_q + 2'd1;

   logic a;
   assign a = sync_out ^ i_active_low;

   logic [CNT_W-1:0] cnt_q, cnt_d, per_q, per_d, per_inc, min_eff;
   chan_state_e      state_q, state_d;
   logic             fire, qual_d, strobe_q, qual_q;
   logic             is_hold, is_rep, is_rel, reach, over;

   // cnt_d is the count including the current sample.
   // The FSM compares against it.
   assign cnt_d   = !a ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE);
   assign min_eff = (i_min_cycles == '0) ? CNT_ONE : i_min_cycles;
   assign reach   = (cnt_d >= min_eff);
   assign over    = (i_max_cycles != '0) && (cnt_d > i_max_cycles);
   assign per_inc = per_q + CNT_ONE;
   assign is_hold = (i_mode == HOLD);
   assign is_rep  = (i_mode == REPEAT);
   assign is_rel  = !is_hold && !is_rep;

   always_comb begin
      state_d = state_q;
      per_d   = per_q;
      fire    = 1'b0;
      case (state_q)
         DISARMED: begin
            if (sample_ok && !a) state_d = IDLE;
         end
         IDLE, COUNT: begin
            if (!a) begin
               state_d = IDLE;
            end else if (reach) begin
               // With max < min, the state goes straight to OVER.
               // RELEASE then cannot fire.
               state_d = over ? OVER : QUAL;
               fire    = !is_rel;
               per_d   = '0;
            end else begin
               state_d = COUNT;
            end
         end
         QUAL, OVER: begin
            if (!a) begin
               state_d = IDLE;
               fire    = is_rel && (state_q == QUAL);
            end else begin
               if ((state_q == QUAL) && over) state_d = OVER;
               // The period counter is separate from cnt. Repeats therefore
               // keep going after the width count saturates.
               if (is_rep) begin
                  if (per_inc >= min_eff) begin
                     fire  = 1'b1;
                     per_d = '0;
                  end else begin
                     per_d = per_inc;
                  end
               end
            end
         end
         default: state_d = DISARMED;
      endcase
   end

   assign qual_d = (state_d == QUAL) || (state_d == OVER);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= DISARMED;
         cnt_q    <= '0;
         per_q    <= '0;
         fill_q   <= '0;
         strobe_q <= 1'b0;
         qual_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         per_q    <= per_d;
         fill_q   <= fill_d;
         strobe_q <= fire;
         qual_q   <= qual_d;
      end
   end

   assign o_fire      = fire;
   assign o_strobe    = strobe_q;
   assign o_qualified = qual_q;
   assign o_state     = state_q;

endmodule

// File: rtl/pulse_width_trigger.sv
// Multi-channel pulse-width qualifier. It sits between board inputs and the
// SoC control and interrupt logic. Each channel is an independent
// pulse_trig_channel.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_in[CHANNELS]        raw asynchronous inputs
//   i_active_low          input polarity, shared by all channels
//   i_mode, i_min_cycles, i_max_cycles   runtime configuration
//   o_strobe[CHANNELS]    one-cycle trigger pulses
//   o_qualified[CHANNELS] asserted and count >= min
//   o_any                 OR of the strobes, registered alongside them
//   o_dbg_state           per-channel FSM state, STATE_W bits per channel
module pulse_width_trigger
   import pulse_trig_pkg::*;
#(
   parameter int CHANNELS    = 4,
   parameter int CNT_W       = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic [CHANNELS-1:0]         i_in,
   input  logic                        i_active_low,
   input  logic [1:0]                  i_mode,
   input  logic [CNT_W-1:0]            i_min_cycles,
   input  logic [CNT_W-1:0]            i_max_cycles,
   output logic [CHANNELS-1:0]         o_strobe,
   output logic [CHANNELS-1:0]         o_qualified,
   output logic                        o_any,
   output logic [CHANNELS*STATE_W-1:0] o_dbg_state
);

   logic [CHANNELS-1:0] fire;
   logic                any_q;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      chan_state_e st;
      pulse_trig_channel #(
         .CNT_W       (CNT_W),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_chan (
         .i_clk        (i_clk),
         .i_rst        (i_rst),
         .i_in         (i_in[c]),
         .i_active_low (i_active_low),
         .i_mode       (i_mode),
         .i_min_cycles (i_min_cycles),
         .i_max_cycles (i_max_cycles),
         .o_fire       (fire[c]),
         .o_strobe     (o_strobe[c]),
         .o_qualified  (o_qualified[c]),
         .o_state      (st)
      );
      assign o_dbg_state[c*STATE_W +: STATE_W] = st;
   end

   // This register is fed from the unregistered fires.
   // o_any therefore lands in the same cycle as o_strobe.
   always_ff @(posedge i_clk) begin
      if (i_rst) any_q <= 1'b0;
      else       any_q <= |fire;
   end

   assign o_any = any_q;

endmodule

// File: tb/tb_pulse_width_trigger.sv
module tb_pulse_width_trigger;
   import pulse_trig_pkg::*;

   localparam int CH = 4;
   localparam int W0 = 24;
   localparam int W1 = 4;
   localparam int S  = 2;

   // ---------------- clock / reset / DUT ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic al  = 1'b0;
   always #5 clk = ~clk;

   logic [CH-1:0]   in0 = '0;
   logic [0:0]      in1 = '0;
   logic [1:0]      mode0 = 2'd0, mode1 = 2'd0;
   logic [W0-1:0]   min0 = 5, max0 = 0;
   logic [W1-1:0]   min1 = 5, max1 = 0;
   logic [CH-1:0]   strobe0, qual0;
   logic            any0;
   logic [CH*3-1:0] dbg0;
   logic [0:0]      strobe1, qual1;
   logic            any1;
   logic [2:0]      dbg1;

   pulse_width_trigger #(.CHANNELS(CH), .CNT_W(W0), .SYNC_STAGES(S)) u_dut0 (
      .i_clk(clk), .i_rst(rst), .i_in(in0), .i_active_low(al), .i_mode(mode0),
      .i_min_cycles(min0), .i_max_cycles(max0), .o_strobe(strobe0),
      .o_qualified(qual0), .o_any(any0), .o_dbg_state(dbg0));

   // A narrow single-channel copy for counter saturation.
   pulse_width_trigger #(.CHANNELS(1), .CNT_W(W1), .SYNC_STAGES(S)) u_dut1 (
      .i_clk(clk), .i_rst(rst), .i_in(in1), .i_active_low(al), .i_mode(mode1),
      .i_min_cycles(min1), .i_max_cycles(max1), .o_strobe(strobe1),
      .o_qualified(qual1), .o_any(any1), .o_dbg_state(dbg1));

   // ---------------- scoreboard ----------------
   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   logic [11:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   // Channels 0..3 belong to dut0 and channel 4 to dut1. The model works on
   // run lengths: a pulse of width w qualifies if min <= w <= max.
   // HOLD fires at w == min. REPEAT fires at every multiple of min.
   int run[5];
   bit armed[5];
   int hist[5][$];   // pin delay line; -1 = synchroniser still flushing

   function automatic void model_reset(input int c);
      run[c] = 0;
      armed[c] = 1'b0;
      hist[c].delete();
      for (int i = 0; i < S; i++) hist[c].push_back(-1);
   endfunction

   function automatic void model_step(input int c, input int s, output bit st, output bit q);
      int m, mx, md, sat, w;
      bit rel;
      md  = (c == 4) ? int'(mode1) : int'(mode0);
      m   = (c == 4) ? int'(min1)  : int'(min0);
      mx  = (c == 4) ? int'(max1)  : int'(max0);
      sat = (c == 4) ? (1 << W1) - 1 : (1 << W0) - 1;
      if (m == 0) m = 1;
      rel = (md == 0) || (md == 3);
      st = 1'b0;
      q  = 1'b0;
      if (s < 0) begin
         run[c] = 0;
      end else if (s == 0) begin
         w = (run[c] > sat) ? sat : run[c];
         if (rel && armed[c] && run[c] >= m && (mx == 0 || w <= mx)) st = 1'b1;
         run[c]   = 0;
         armed[c] = 1'b1;
      end else if (armed[c]) begin
         run[c]++;
         q = (run[c] >= m);
         if (md == 1)      st = (run[c] == m);
         else if (md == 2) st = (run[c] >= m) && ((run[c] - m) % m == 0);
      end
   endfunction

   // ---------------- statistics for directed checks ----------------
   int st_cnt[5];
   int q_cnt[5];
   int any_cnt;
   int last_st_cyc;
   logic [3:0] st_pat;

   task automatic clear_stats();
      for (int c = 0; c < 5; c++) begin
         st_cnt[c] = 0;
         q_cnt[c] = 0;
      end
      any_cnt = 0;
      last_st_cyc = -1;
      st_pat = '0;
   endtask

   // ---------------- driver ----------------
   // as0/as1 are asserted levels. Pins are derived from them using the polarity.
   task automatic cycle(input logic [3:0] as0, input logic as1);
      logic [3:0] es0, eq0;
      logic es1, eq1;
      logic [11:0] e;
      bit st, q;
      int s;
      in0 = as0 ^ {4{al}};
      in1 = as1 ^ al;
      es1 = 1'b0;
      eq1 = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (rst) begin
            model_reset(c);
            st = 1'b0;
            q = 1'b0;
         end else begin
            hist[c].push_back((c == 4) ? int'(as1) : int'(as0[c]));
            s = hist[c].pop_front();
            model_step(c, s, st, q);
         end
         if (c < 4) begin
            es0[c] = st;
            eq0[c] = q;
         end else begin
            es1 = st;
            eq1 = q;
         end
      end
      exp_q.push_back({es1, eq1, es1, |es0, eq0, es0});
      @(posedge clk);
      @(negedge clk);
      cyc++;
      e = exp_q.pop_front();
      check("strobe0", strobe0, e[3:0]);
      check("qual0",   qual0,   e[7:4]);
      check("any0",    any0,    e[8]);
      check("strobe1", strobe1, e[9]);
      check("qual1",   qual1,   e[10]);
      check("any1",    any1,    e[11]);
      for (int c = 0; c < 4; c++) begin
         if (strobe0[c]) st_cnt[c]++;
         if (qual0[c])   q_cnt[c]++;
      end
      if (strobe1[0]) st_cnt[4]++;
      if (qual1[0])   q_cnt[4]++;
      if (any0) any_cnt++;
      if (strobe0 != '0) begin
         st_pat = strobe0;
         last_st_cyc = cyc;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(4'b0000, 1'b0);
   endtask

   task automatic reset_dut(input logic new_al);
      rst = 1'b1;
      al = new_al;
      repeat (3) cycle(4'b0000, 1'b0);
      rst = 1'b0;
      idle(6);
   endtask

   task automatic pulse0(input int ch, input int width);
      repeat (width) cycle(4'(1 << ch), 1'b0);
      idle(8);
   endtask

   function automatic logic [11:0] all_state(input chan_state_e s);
      logic [11:0] v;
      for (int c = 0; c < 4; c++) v[c*3 +: 3] = s;
      return v;
   endfunction

   // ---------------- stimulus ----------------
   int fall_cyc;
   logic [4:0] lvl;
   int rem[5];

   initial begin
      clear_stats();
      for (int c = 0; c < 5; c++) model_reset(c);

      // Reset state.
      rst = 1'b1;
      repeat (3) cycle(4'b0000, 1'b0);
      check("rst_state0", dbg0, all_state(DISARMED));
      check("rst_state1", dbg1, 3'(DISARMED));
      rst = 1'b0;
      idle(6);
      check("armed_idle0", dbg0, all_state(IDLE));

      // RELEASE thresholds.
      mode0 = 2'd0; min0 = 5; max0 = 0;
      clear_stats();
      pulse0(0, 4);
      check("t1_w4_none", st_cnt[0], 0);
      clear_stats();
      repeat (5) cycle(4'b0001, 1'b0);
      fall_cyc = cyc + 1;
      idle(8);
      check("t1_w5_one", st_cnt[0], 1);
      check("t1_latency", last_st_cyc - fall_cyc + 1, S + 1);
      check("t1_any", any_cnt, 1);

      // Max window.
      min0 = 3; max0 = 8;
      clear_stats(); pulse0(0, 8);
      check("t2_w8", st_cnt[0], 1);
      clear_stats(); pulse0(0, 9);
      check("t2_w9", st_cnt[0], 0);
      min0 = 10; max0 = 8;
      clear_stats(); pulse0(0, 9);
      check("t2_maxltmin", st_cnt[0], 0);

      // HOLD with active-low inputs.
      reset_dut(1'b1);
      mode0 = 2'd1; min0 = 3; max0 = 0;
      clear_stats();
      repeat (20) cycle(4'b0010, 1'b0);
      idle(8);
      check("t3_hold_one", st_cnt[1], 1);
      check("t3_qual_len", q_cnt[1], 18);

      // REPEAT, including the saturating 4-bit counter.
      reset_dut(1'b0);
      mode0 = 2'd2; min0 = 4;
      clear_stats();
      repeat (13) cycle(4'b0100, 1'b0);
      idle(8);
      check("t4_rep3", st_cnt[2], 3);
      mode1 = 2'd2; min1 = 5; max1 = 0;
      clear_stats();
      repeat (60) cycle(4'b0000, 1'b1);
      idle(8);
      check("t4_rep_sat", st_cnt[4], 12);

      // Input held asserted across reset release.
      mode0 = 2'd0; min0 = 5; max0 = 0;
      rst = 1'b1;
      repeat (3) cycle(4'b0001, 1'b0);
      rst = 1'b0;
      clear_stats();
      repeat (100) cycle(4'b0001, 1'b0);
      check("t5_disarmed", dbg0[2:0], 3'(DISARMED));
      idle(8);
      check("t5_no_strobe", st_cnt[0], 0);
      clear_stats(); pulse0(0, 6);
      check("t5_next_pulse", st_cnt[0], 1);

      // Reset in the middle of a qualified pulse.
      clear_stats();
      repeat (10) cycle(4'b0001, 1'b0);
      rst = 1'b1;
      repeat (2) cycle(4'b0001, 1'b0);
      check("t5_rst_qual", qual0, 0);
      check("t5_rst_state", dbg0, all_state(DISARMED));
      rst = 1'b0;
      idle(10);
      check("t5_rst_none", st_cnt[0], 0);

      // Simultaneous channels.
      min0 = 2;
      clear_stats();
      repeat (5) cycle(4'b1000, 1'b0);
      repeat (2) cycle(4'b1001, 1'b0);
      idle(8);
      check("t6_pattern", st_pat, 4'b1001);
      check("t6_count", st_cnt[0] + st_cnt[3], 2);

      // Randomized bursts against the model.
      for (int b = 0; b < 12; b++) begin
         reset_dut(1'($urandom_range(0, 1)));
         mode0 = 2'($urandom_range(0, 3));
         min0  = W0'($urandom_range(0, 12));
         max0  = ($urandom_range(0, 2) == 0) ? '0 : W0'($urandom_range(1, 20));
         mode1 = 2'($urandom_range(0, 3));
         min1  = W1'($urandom_range(0, 8));
         max1  = ($urandom_range(0, 2) == 0) ? '0 : W1'($urandom_range(1, 15));
         lvl = '0;
         for (int c = 0; c < 5; c++) rem[c] = $urandom_range(1, 10);
         repeat (300) begin
            for (int c = 0; c < 5; c++) begin
               if (rem[c] == 0) begin
                  lvl[c] = ~lvl[c];
                  rem[c] = $urandom_range(1, 25);
               end
               rem[c]--;
            end
            cycle(lvl[3:0], lvl[4]);
         end
         idle(10);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
